// File: rtl/uart_ctrl_pkg.sv
// UART command scheduler shared types and constants.
// Holds the FSM state enum, UART op codes and baud-rate select codes.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] RATE_DEF  = 2'b00;
  localparam logic [1:0] RATE_9600 = 2'b01;
  localparam logic [1:0] RATE_50K  = 2'b10;
  localparam logic [1:0] RATE_115K = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a stored pointer.
// Ports: req in, upd (advance pointer past winner), gnt/gnt_idx/any out.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [NREQ-1:0]         req,
  input  logic                    upd,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin : sel
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx[PW-1:0];
      end
    end
  end

  // Pointer only moves on an actual grant, so it holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (upd && any) begin
      if (gnt_idx == PW'(NREQ - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_cmd_sched.sv
// Schedules write/read/clear ops onto a single edge-triggered UART port.
// Ports: req_* writers, rd_* reader, clear_req, rate_sel, uart_* side, busy.
module uart_cmd_sched #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rd_req,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  input  logic [1:0]        rate_sel,
  output logic [3:0]        uart_control,
  output logic [7:0]        uart_tx_data,
  input  logic [7:0]        uart_rx_data,
  output logic              busy
);

  import uart_ctrl_pkg::*;

  state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] rate_q, rate_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rdd_q, rdd_d;
  logic       rdv_q, rdv_d;
  logic       busy_q, busy_d;
  logic       clr_q, clr_d;
  logic       is_rd_q, is_rd_d;
  logic       sel_wr;

  logic [NREQ-1:0]         gnt;
  logic [$clog2(NREQ)-1:0] gnt_idx;
  logic                    any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .nReset  (nReset),
    .req     (req_valid),
    .upd     (sel_wr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    op_d    = OP_IDLE;
    rate_d  = rate_q;
    tx_d    = tx_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
    is_rd_d = is_rd_q;
    sel_wr  = 1'b0;
    clr_d   = clr_q | clear_req;
    unique case (state_q)
      ST_IDLE: begin
        rate_d = rate_sel;
        if (clr_q || clear_req) begin
          op_d    = OP_CLEAR;
          state_d = ST_ISSUE;
          clr_d   = 1'b0;
          is_rd_d = 1'b0;
        // The reader still holds rd_req while rd_valid is up.
        end else if (rd_req && !rdv_q) begin
          op_d    = OP_READ;
          state_d = ST_ISSUE;
          is_rd_d = 1'b1;
        end else if (any) begin
          sel_wr  = 1'b1;
          op_d    = OP_WRITE;
          tx_d    = req_data[8*gnt_idx +: 8];
          state_d = ST_ISSUE;
          is_rd_d = 1'b0;
        end
      end
      ST_ISSUE: state_d = ST_GAP;
      ST_GAP: begin
        state_d = ST_IDLE;
        if (is_rd_q) begin
          rdd_d = uart_rx_data;
          rdv_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_IDLE;
      rate_q  <= RATE_DEF;
      tx_q    <= '0;
      rdd_q   <= '0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rate_q  <= rate_d;
      tx_q    <= tx_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      is_rd_q <= is_rd_d;
    end
  end

  assign req_ready    = gnt & {NREQ{sel_wr}};
  assign uart_control = {op_q, rate_q};
  assign uart_tx_data = tx_q;
  assign rd_data      = rdd_q;
  assign rd_valid     = rdv_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed self-checking bench for uart_cmd_sched.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_uart_cmd_sched;

  logic        clk = 1'b0;
  logic        nReset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        clear_req;
  logic [1:0]  rate_sel;
  logic [3:0]  uart_control;
  logic [7:0]  uart_tx_data;
  logic [7:0]  uart_rx_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int gord;

  uart_cmd_sched #(.NREQ(4)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .clear_req    (clear_req),
    .rate_sel     (rate_sel),
    .uart_control (uart_control),
    .uart_tx_data (uart_tx_data),
    .uart_rx_data (uart_rx_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    req_valid = '0;
    req_data = 32'h0;
    rd_req = 1'b0;
    clear_req = 1'b0;
    rate_sel = 2'b00;
    uart_rx_data = 8'h00;
    cyc();
    cyc();
    #1;
    chk("rst_ctrl", uart_control, 4'b0000);
    chk("rst_tx", uart_tx_data, 8'h00);
    chk("rst_rdd", rd_data, 8'h00);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", req_ready, 4'b0000);
    nReset = 1'b1;
    cyc();

    // fairness: 0,1,2,3,0 every 3 cycles
    req_data = 32'h44332211;
    req_valid = 4'hF;
    for (int c = 0; c < 15; c++) begin
      #1;
      gord = (c / 3) % 4;
      if (c % 3 == 0) chk("rr_gnt", req_ready, 4'b0001 << gord);
      else            chk("rr_gap", req_ready, 4'b0000);
      if (c == 14) req_valid = '0;
      cyc();
    end

    // write from requester 2
    req_data = 32'h33A52211;
    req_valid = 4'b0100;
    #1;
    chk("wr_rdy", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    #1;
    chk("wr_op1", uart_control[3:2], 2'b01);
    chk("wr_tx1", uart_tx_data, 8'hA5);
    chk("wr_busy", busy, 1'b1);
    cyc();
    #1;
    chk("wr_op2", uart_control[3:2], 2'b00);
    chk("wr_tx2", uart_tx_data, 8'hA5);
    cyc();
    #1;
    chk("wr_idle", busy, 1'b0);

    // read with simultaneous write from requester 0
    req_data = 32'h0000005A;
    req_valid = 4'b0001;
    rd_req = 1'b1;
    #1;
    chk("rd_prio", req_ready, 4'b0000);
    cyc();
    #1;
    chk("rd_op1", uart_control[3:2], 2'b10);
    cyc();
    uart_rx_data = 8'h3C;
    #1;
    chk("rd_op2", uart_control[3:2], 2'b00);
    chk("rd_v2", rd_valid, 1'b0);
    cyc();
    uart_rx_data = 8'hFF;
    #1;
    chk("rd_v3", rd_valid, 1'b1);
    chk("rd_d3", rd_data, 8'h3C);
    chk("rd_wr_next", req_ready, 4'b0001);
    cyc();
    rd_req = 1'b0;
    req_valid = '0;
    #1;
    chk("rd_wr_op", uart_control[3:2], 2'b01);
    chk("rd_wr_tx", uart_tx_data, 8'h5A);
    chk("rd_v4", rd_valid, 1'b0);
    cyc();
    #1;
    chk("rd_wr_gap", uart_control[3:2], 2'b00);
    cyc();
    #1;
    chk("rd_idle", busy, 1'b0);

    // clear pulses during a write merge into one clear
    req_data = 32'h00007700;
    req_valid = 4'b0010;
    #1;
    chk("cl_wr_rdy", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    clear_req = 1'b1;
    #1;
    chk("cl_wr_op", uart_control[3:2], 2'b01);
    cyc();
    #1;
    cyc();
    clear_req = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("cl_prio", req_ready, 4'b0000);
    cyc();
    #1;
    chk("cl_op11", uart_control[3:2], 2'b11);
    cyc();
    #1;
    chk("cl_op00", uart_control[3:2], 2'b00);
    cyc();
    #1;
    chk("cl_wr2_rdy", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    #1;
    chk("cl_once", uart_control[3:2], 2'b01);
    cyc();
    #1;
    cyc();
    #1;
    chk("cl_idle", busy, 1'b0);

    // rate change while busy
    req_valid = 4'b0100;
    #1;
    chk("rt_rdy", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    rate_sel = 2'b11;
    #1;
    chk("rt_b1", uart_control[1:0], 2'b00);
    cyc();
    #1;
    chk("rt_b2", uart_control[1:0], 2'b00);
    cyc();
    #1;
    chk("rt_idle", uart_control[1:0], 2'b00);
    cyc();
    #1;
    chk("rt_new", uart_control, 4'b0011);

    // reset during the ISSUE cycle of a read
    rd_req = 1'b1;
    cyc();
    #1;
    chk("rs_issue", uart_control, 4'b1011);
    nReset = 1'b0;
    cyc();
    uart_rx_data = 8'h99;
    #1;
    chk("rs_ctrl", uart_control, 4'b0000);
    chk("rs_busy", busy, 1'b0);
    nReset = 1'b1;
    rd_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      chk("rs_no_rdv", rd_valid, 1'b0);
    end
    chk("rs_rdd", rd_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sched.md
UART_CMD_SCHED -- requirements
Module: uart_cmd_sched

Interface
REQ-001 Parameter NREQ, default 4, is the number of transmit requesters (2..8).
REQ-002 Clock and reset are decided: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nReset  in  1  synchronous active-low reset.
REQ-005 req_valid  in  NREQ  per-requester transmit byte pending.
REQ-006 req_data  in  8*NREQ  per-requester byte, slice i = bits [8i+7:8i].
REQ-007 req_ready  out  NREQ  one-cycle grant pulse; the byte is consumed that cycle.
REQ-008 rd_req  in  1  request one byte from the UART receive buffer; held until rd_valid.
REQ-009 rd_data  out  8  byte returned by the UART.
REQ-010 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-011 clear_req  in  1  pulse requesting that both UART buffers be cleared.
REQ-012 rate_sel  in  2  baud select: 00 default, 01 9600, 10 50000, 11 115200.
REQ-013 uart_control  out  4  UART control: [3:2] op, [1:0] rate.
REQ-014 uart_tx_data  out  8  byte presented to the UART write port.
REQ-015 uart_rx_data  in  8  UART read port; valid only in the cycle after a read op is asserted.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 Op codes on uart_control[3:2] shall be: 00 IDLE, 01 WRITE, 10 READ, 11 CLEAR.
REQ-018 The UART acts on a 00->non-00 op edge, so every op shall be asserted for exactly one cycle and then followed by at least one cycle of 00.
REQ-019 FSM states shall be IDLE, ISSUE and GAP; transitions are IDLE->ISSUE on a selected op, ISSUE->GAP always, and GAP->IDLE always.
REQ-020 In IDLE the block shall select, in priority order, a pending clear, then rd_req, then the round-robin winner among req_valid.
REQ-021 A write grant shall pulse req_ready[i] in the IDLE selection cycle T and latch req_data slice i into uart_tx_data.
REQ-022 For a write, uart_control[3:2] shall be 01 at T+1 and 00 at T+2, and uart_tx_data shall hold the latched byte through T+2.
REQ-023 For a read, the op shall be 10 at T+1, rd_data shall be captured from uart_rx_data at T+2, and rd_valid shall pulse at T+3.
REQ-024 A clear shall drive op 11 at T+1 and 00 at T+2.
REQ-025 Sustained throughput shall be one op per 3 cycles, with the next selection no earlier than T+3.
REQ-026 Round-robin: after granting requester i, the search shall start at i+1 mod NREQ; when nothing is pending the pointer holds.
REQ-027 A clear_req arriving while busy shall set a pending-clear flag, and multiple pulses shall merge into one clear.
REQ-028 A pending clear shall be dropped once issued.
REQ-029 rate_sel shall be registered into uart_control[1:0] only in IDLE; it is held constant while busy.
REQ-030 A req_valid deassert before grant shall be allowed; no grant shall be issued to a non-valid requester.
REQ-031 rd_req and req_valid pending in the same cycle shall be resolved as read first; the writer is granted on the next selection.
REQ-032 All outputs except req_ready shall be registered.

Reset
REQ-033 With nReset low at a clk edge the block shall return to: state IDLE, uart_control 0000, uart_tx_data 00, rd_data 00, rd_valid 0, req_ready 0, busy 0, RR pointer 0, pending-clear 0.
REQ-034 A reset mid-operation shall abandon the op without completing its GAP cycle and without issuing a grant or rd_valid.

Structure
REQ-035 Package uart_ctrl_pkg shall hold the state enum, the op-code constants and the rate-select constants.
REQ-036 Round-robin selection shall live in one sub-module, rr_arbiter (NREQ-parameterised, one-hot grant, pointer update input).

Verification
REQ-037 Write: req_valid[2]=1, req_data slice 2=0xA5 -> req_ready[2] at T, control[3:2]=01 with tx_data=0xA5 at T+1, and 00 with 0xA5 at T+2.
REQ-038 Fairness: all four requesters valid continuously -> grants in order 0,1,2,3,0, spaced 3 cycles apart.
REQ-039 Read: rd_req=1, uart_rx_data=0x3C at T+2 -> control[3:2]=10 at T+1, rd_valid with rd_data=0x3C at T+3, and rd_req has priority over a simultaneous write.
REQ-040 Clear: clear_req pulsed twice during a write -> after that write's GAP, exactly one op 11, followed by 00.
REQ-041 Rate: rate_sel changes 00->11 while busy -> control[1:0] stays 00 until IDLE, then becomes 11.
REQ-042 Reset: nReset low in the ISSUE cycle of a read -> next cycle control=0000, and no rd_valid afterward.
